// File: rtl/odd_count_checker.sv
// Tracks an upstream odd-only counter (1,3,...,15,1,...), locks onto its sequence,
// and reports mismatches and wrap-arounds through saturating counters.
module odd_count_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       count_in,
  input  logic             up_reset,
  input  logic             clear,
  output logic             locked,
  output logic [3:0]       expected,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {SEARCH, TRACK, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_locked;
  logic [3:0]       r_expected;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_wrap_count;

  logic [3:0] w_next;
  logic       w_tracking;
  logic       w_match;
  logic       w_mismatch;
  logic       w_wrap;

  // Odd sequence successor: 15 wraps back to 1.
  assign w_next     = (count_in == 4'd15) ? 4'd1 : (count_in + 4'd2);
  assign w_tracking = (r_state == TRACK) && !up_reset;
  assign w_match    = w_tracking && (count_in == r_expected);
  assign w_mismatch = w_tracking && (count_in != r_expected);
  assign w_wrap     = w_match && (count_in == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_locked     <= 1'b0;
      r_expected   <= 4'd1;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_err_pulse <= w_mismatch;

      if (up_reset) begin
        r_state  <= HOLD;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          SEARCH: begin
            if (count_in[0]) begin
              r_expected <= w_next;
              r_state    <= TRACK;
              r_locked   <= 1'b1;
            end
          end
          TRACK: begin
            if (w_match) begin
              r_expected <= w_next;
            end else begin
              r_state  <= SEARCH;
              r_locked <= 1'b0;
            end
          end
          HOLD: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Clear wipes history but a same-cycle event still lands as the first count.
      if (clear) begin
        r_err_count  <= {{(CNT_W-1){1'b0}}, w_mismatch};
        r_wrap_count <= {{(CNT_W-1){1'b0}}, w_wrap};
        r_err_sticky <= w_mismatch;
      end else begin
        if (w_mismatch) begin
          r_err_sticky <= 1'b1;
          if (r_err_count != CNT_MAX) r_err_count <= r_err_count + 1'b1;
        end
        if (w_wrap && (r_wrap_count != CNT_MAX)) begin
          r_wrap_count <= r_wrap_count + 1'b1;
        end
      end
    end
  end

  assign locked     = r_locked;
  assign expected   = r_expected;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_odd_count_checker.sv
// Self-checking bench for odd_count_checker: directed vector table, random run
// against a behavioural model, saturation/clear and asynchronous reset sequences.
module tb_odd_count_checker;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       count_in;
  logic             up_reset;
  logic             clear;
  logic             locked;
  logic [3:0]       expected;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  odd_count_checker #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .up_reset   (up_reset),
    .clear      (clear),
    .locked     (locked),
    .expected   (expected),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  // Behavioural reference: what the checker believes about the upstream counter.
  bit m_following;  // locked onto the sequence
  bit m_paused;     // upstream held in reset (or just released)
  int m_exp, m_err, m_wrap;
  bit m_pulse, m_sticky;

  function automatic int succ(int x);
    return (x == 15) ? 1 : (x + 2) % 16;
  endfunction

  task automatic model_reset();
    m_following = 0; m_paused = 0;
    m_exp = 1; m_err = 0; m_wrap = 0; m_pulse = 0; m_sticky = 0;
  endtask

  task automatic model_step(int cin, bit upr, bit clr);
    bit bad, wrapped;
    bad = 0; wrapped = 0;
    if (upr) begin
      m_paused = 1; m_following = 0;
    end else if (m_paused) begin
      m_paused = 0;
    end else if (m_following) begin
      if (cin == m_exp) begin
        wrapped = (cin == 15);
        m_exp = succ(cin);
      end else begin
        bad = 1; m_following = 0;
      end
    end else if (cin % 2 == 1) begin
      m_exp = succ(cin); m_following = 1;
    end
    m_pulse = bad;
    if (clr) begin
      m_err = bad ? 1 : 0; m_wrap = wrapped ? 1 : 0; m_sticky = bad;
    end else begin
      if (bad) begin
        m_sticky = 1;
        if (m_err < CMAX) m_err++;
      end
      if (wrapped && m_wrap < CMAX) m_wrap++;
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".locked"},     int'(locked),     int'(m_following));
    check({tag, ".expected"},   int'(expected),   m_exp);
    check({tag, ".err_pulse"},  int'(err_pulse),  int'(m_pulse));
    check({tag, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
    check({tag, ".err_count"},  int'(err_count),  m_err);
    check({tag, ".wrap_count"}, int'(wrap_count), m_wrap);
  endtask

  // Drive away from the active edge, sample 1 time unit after it.
  task automatic step(int cin, bit upr, bit clr);
    @(negedge clk);
    count_in = 4'(cin); up_reset = upr; clear = clr;
    @(posedge clk);
    #1;
    model_step(cin, upr, clr);
    check_model("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; count_in = 0; up_reset = 0; clear = 0;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    int cin; bit upr; bit clr;
    bit lck; int exp; bit pls; bit stk; int err; int wrp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(int cin, bit upr, bit clr, bit lck, int exp, bit pls, bit stk, int err, int wrp);
    vec_t v;
    v.cin = cin; v.upr = upr; v.clr = clr;
    v.lck = lck; v.exp = exp; v.pls = pls; v.stk = stk; v.err = err; v.wrp = wrp;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1; count_in = 0; up_reset = 0; clear = 0;
    model_reset();
    #1;
    check("rst.locked",     int'(locked),     0);
    check("rst.expected",   int'(expected),   1);
    check("rst.err_pulse",  int'(err_pulse),  0);
    check("rst.err_sticky", int'(err_sticky), 0);
    check("rst.err_count",  int'(err_count),  0);
    check("rst.wrap_count", int'(wrap_count), 0);
    @(negedge clk);
    reset = 0;

    // cin upr clr | locked exp pulse sticky err wrap
    for (int k = 1; k <= 15; k += 2) add(k, 0, 0, 1, succ(k), 0, 0, 0, (k == 15) ? 1 : 0);
    add( 1, 0, 0, 1,  3, 0, 0, 0, 1);
    add( 0, 1, 0, 0,  3, 0, 0, 0, 1);  // upstream restart -> hold
    add( 4, 0, 0, 0,  3, 0, 0, 0, 1);  // leave hold
    add( 4, 0, 0, 0,  3, 0, 0, 0, 1);  // even in search: silent
    add( 7, 0, 0, 1,  9, 0, 0, 0, 1);
    add( 6, 0, 0, 0,  9, 1, 1, 1, 1);  // mismatch
    add(11, 0, 0, 1, 13, 0, 1, 1, 1);  // relock
    add(13, 0, 0, 1, 15, 0, 1, 1, 1);
    add( 1, 1, 0, 0, 15, 0, 1, 1, 1);
    add( 1, 1, 0, 0, 15, 0, 1, 1, 1);
    add( 1, 0, 0, 0, 15, 0, 1, 1, 1);
    add( 3, 0, 0, 1,  5, 0, 1, 1, 1);
    add( 5, 0, 0, 1,  7, 0, 1, 1, 1);
    add( 7, 0, 1, 1,  9, 0, 0, 0, 0);  // plain clear keeps lock
    add( 9, 0, 0, 1, 11, 0, 0, 0, 0);
    add(11, 0, 0, 1, 13, 0, 0, 0, 0);
    add(13, 0, 0, 1, 15, 0, 0, 0, 0);
    add(15, 0, 1, 1,  1, 0, 0, 0, 1);  // clear with matched 15

    foreach (vecs[i]) begin
      step(vecs[i].cin, vecs[i].upr, vecs[i].clr);
      check($sformatf("vec%0d.locked", i),   int'(locked),     int'(vecs[i].lck));
      check($sformatf("vec%0d.expected", i), int'(expected),   vecs[i].exp);
      check($sformatf("vec%0d.pulse", i),    int'(err_pulse),  int'(vecs[i].pls));
      check($sformatf("vec%0d.sticky", i),   int'(err_sticky), int'(vecs[i].stk));
      check($sformatf("vec%0d.err", i),      int'(err_count),  vecs[i].err);
      check($sformatf("vec%0d.wrap", i),     int'(wrap_count), vecs[i].wrp);
      $display("vec %0d: cin=%0d upr=%0b clr=%0b -> locked=%0b exp=%0d pulse=%0b err=%0d wrap=%0d",
               i, vecs[i].cin, vecs[i].upr, vecs[i].clr, locked, expected, err_pulse, err_count, wrap_count);
    end

    // Random run, biased towards following the sequence so wraps occur.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      int cin; bit upr, clr;
      cin = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 15));
      upr = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 19) == 0);
      step(cin, upr, clr);
      $display("rnd %0d: cin=%0d upr=%0b clr=%0b -> locked=%0b exp=%0d err=%0d wrap=%0d",
               i, cin, upr, clr, locked, expected, err_count, wrap_count);
    end

    // Error counter saturation, then clear coinciding with a mismatch.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    check("sat.err_count", int'(err_count), CMAX);
    $display("sat: err_count=%0d after 300 mismatches", err_count);
    step(1, 0, 0);
    step(0, 0, 1);
    check("clrmis.err_count",  int'(err_count),  1);
    check("clrmis.err_sticky", int'(err_sticky), 1);
    check("clrmis.err_pulse",  int'(err_pulse),  1);
    check("clrmis.wrap_count", int'(wrap_count), 0);
    $display("clear+mismatch: err_count=%0d sticky=%0b", err_count, err_sticky);

    // Asynchronous reset pulsed between edges while tracking.
    step(3, 0, 0);
    step(5, 0, 0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    model_reset();
    check("arst.locked",     int'(locked),     0);
    check("arst.expected",   int'(expected),   1);
    check("arst.err_pulse",  int'(err_pulse),  0);
    check("arst.err_sticky", int'(err_sticky), 0);
    check("arst.err_count",  int'(err_count),  0);
    check("arst.wrap_count", int'(wrap_count), 0);
    $display("async reset: locked=%0b expected=%0d err=%0d", locked, expected, err_count);
    #1 reset = 0;
    step(7, 0, 0);
    check("arst.relock", int'(locked), 1);
    check("arst.relock_exp", int'(expected), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
